disp_mux_n_amisha: RTL
======================

// Module: disp_mux_n_amisha
// PURPOSE
//  Parametrised N-digit multiplexed seven-segment driver for the board-level display path.
//  Time-multiplexes N hex digits onto one shared active-low segment bus with one-hot active-low anodes.
//  Adds three capabilities: tear-free double-buffered loads, per-digit blanking/decimal point, and PWM brightness.
//  Sits between the switch/button front-end and the board display pins.
// PARAMETERS
//  N_DIGITS      4   number of digits/anodes (2..8)
//  REFRESH_BITS  18  prescaler width; one digit slot = 2**REFRESH_BITS clocks
//  BRIGHT_W      4   brightness code width; PWM uses top BRIGHT_W prescaler bits
// PORTS
//  clk_amisha      in   1           system clock, rising edge
//  reset_n_amisha  in   1           asynchronous reset, active-low
//  hex_amisha      in   4*N_DIGITS  digit i nibble = [4i+3:4i]; digit 0 = rightmost
//  dp_amisha       in   N_DIGITS    decimal point request per digit, 1 = lit
//  blank_amisha    in   N_DIGITS    1 = digit dark (anode held off)
//  bright_amisha   in   BRIGHT_W    brightness; 0 = off, all-ones = full on
//  load_amisha     in   1           1-cycle strobe; captures hex/dp/blank into shadow regs
//  an_amisha       out  N_DIGITS    anodes, active-low, at most one low
//  sseg_amisha     out  8           {dp,g,f,e,d,c,b,a}, active-low
//  frame_amisha    out  1           1-cycle pulse when the last digit slot ends
// BEHAVIOUR
//  Reset: all counters, shadow and active regs = 0; an_amisha = all 1; sseg_amisha = 8'hFF; frame_amisha = 0.
//  Prescaler: free-running REFRESH_BITS counter. On wrap (all-ones -> 0), the digit index advances.
//  Digit index: 0..N_DIGITS-1. It wraps to 0 after N_DIGITS-1; non-power-of-2 N must not visit illegal indices.
//  Frame end: the wrap from N_DIGITS-1 to 0 is the frame boundary.
//    - frame_amisha pulses in the same cycle the index returns to 0.
//    - The shadow->active copy happens on that same edge.
//  Load:
//    - load_amisha=1 captures inputs into shadow on that edge.
//    - Last load before a boundary wins.
//    - A load on the boundary cycle itself goes to shadow only; it is applied at the next boundary.
//  Display always uses the active regs, so there is never a mid-frame change.
//  Decode: nibble -> segments via the hex table (0-F, standard a-g). dp bit = ~active_dp[idx].
//  PWM: pw = prescaler[REFRESH_BITS-1 -: BRIGHT_W].
//    - The anode is enabled iff (bright == all-ones) || (pw < bright).
//    - bright_amisha is sampled live, not double-buffered.
//  Output gating:
//    - When blank[idx]=1 or PWM is off: an_amisha = all 1 and sseg_amisha = 8'hFF.
//    - Otherwise: an_amisha = ~(1<<idx).
//  Latency: an/sseg are registered, 1 clock after the index/prescaler state (glitch-free pins).
//  Reset mid-operation: everything returns to reset values at once, and the pending shadow is discarded.
//    - After release, the first frame shows zeros until the first boundary following a load.
// STRUCTURE
//  Include file disp_defs_amisha.vh holds:
//    - the segment constants SEG_0..SEG_F (active-low 7-bit)
//    - SEG_OFF = 8'hFF
//  Sub-module hex_to_sseg_amisha: combinational nibble -> 7-bit segment decode; one instance, muxed input.
//  Top level holds the prescaler, index counter, shadow/active regs, PWM compare and output regs.
// TESTING  (bench uses REFRESH_BITS=4, BRIGHT_W=2, N_DIGITS=4)
//  1. Hold reset low, toggle clk -> an=4'hF, sseg=8'hFF, frame=0. Release; no load -> digits show SEG_0.
//  2. load hex=16'h12AF, dp=4'b0100, blank=0, bright=3 -> after next frame pulse:
//       an cycles E,D,B,7 every 16 clks; sseg shows F,A,2,1; digit2 dp bit 0.
//  3. load hex=16'h1234 mid-frame -> current frame keeps the old values; change appears exactly at frame pulse.
//  4. blank=4'b1010 -> an never 4'hD or 4'h7; sseg=8'hFF in those slots.
//  5. bright=1 -> each anode low only while pw==0 (4 of 16 clks per slot); bright=0 -> an stays 4'hF.
//  6. Assert reset mid-slot with a pending load -> outputs reset asynchronously; pending values never shown.
//       Also: N_DIGITS=3 run -> index sequence 0,1,2,0; frame pulse every 48 clks.

Source files
------------

// File: rtl/disp_mux_n_amisha_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : disp_mux_n_amisha_pkg                                     |
// | Purpose  : shared types and segment constants for the display mux    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package disp_mux_n_amisha_pkg;

    `include "disp_defs_amisha.vh"

    typedef logic [6:0] seg7_t;
    typedef logic [7:0] sseg_t;

    // Assemble the pin byte: dp is active-low, so a lit request drives 0.
    function automatic sseg_t pack_sseg(input logic dp_lit, input seg7_t seg);
        return {~dp_lit, seg};
    endfunction

endpackage
`default_nettype wire

// File: rtl/disp_defs_amisha.vh
`ifndef DISP_DEFS_AMISHA_VH
`define DISP_DEFS_AMISHA_VH
`default_nettype none
// +----------------------------------------------------------------------+
// | File     : disp_defs_amisha.vh                                       |
// | Contents : active-low seven-segment glyphs {g,f,e,d,c,b,a}, 0-F      |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
localparam logic [6:0] SEG_0   = 7'b100_0000;
localparam logic [6:0] SEG_1   = 7'b111_1001;
localparam logic [6:0] SEG_2   = 7'b010_0100;
localparam logic [6:0] SEG_3   = 7'b011_0000;
localparam logic [6:0] SEG_4   = 7'b001_1001;
localparam logic [6:0] SEG_5   = 7'b001_0010;
localparam logic [6:0] SEG_6   = 7'b000_0010;
localparam logic [6:0] SEG_7   = 7'b111_1000;
localparam logic [6:0] SEG_8   = 7'b000_0000;
localparam logic [6:0] SEG_9   = 7'b001_0000;
localparam logic [6:0] SEG_A   = 7'b000_1000;
localparam logic [6:0] SEG_B   = 7'b000_0011;
localparam logic [6:0] SEG_C   = 7'b100_0110;
localparam logic [6:0] SEG_D   = 7'b010_0001;
localparam logic [6:0] SEG_E   = 7'b000_0110;
localparam logic [6:0] SEG_F   = 7'b000_1110;
localparam logic [7:0] SEG_OFF = 8'hFF;
`default_nettype wire
`endif

// File: rtl/hex_to_sseg_amisha.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : hex_to_sseg_amisha                                        |
// | Purpose  : combinational hex nibble to active-low 7-segment decode    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module hex_to_sseg_amisha
    import disp_mux_n_amisha_pkg::*;
(
    input  logic [3:0] nibble_i,
    output seg7_t      seg_o
);

    always_comb begin
        seg_o = SEG_8;
        case (nibble_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = SEG_A;
            4'hB: seg_o = SEG_B;
            4'hC: seg_o = SEG_C;
            4'hD: seg_o = SEG_D;
            4'hE: seg_o = SEG_E;
            4'hF: seg_o = SEG_F;
            default: seg_o = SEG_8;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/disp_mux_n_amisha.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : disp_mux_n_amisha                                         |
// | Purpose  : N-digit multiplexed 7-seg driver, double-buffered, PWM    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module disp_mux_n_amisha
    import disp_mux_n_amisha_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int REFRESH_BITS = 18,
    parameter int BRIGHT_W     = 4
)(
    input  logic                    clk_amisha,
    input  logic                    reset_n_amisha,
    input  logic [4*N_DIGITS-1:0]   hex_amisha,
    input  logic [N_DIGITS-1:0]     dp_amisha,
    input  logic [N_DIGITS-1:0]     blank_amisha,
    input  logic [BRIGHT_W-1:0]     bright_amisha,
    input  logic                    load_amisha,
    output logic [N_DIGITS-1:0]     an_amisha,
    output logic [7:0]              sseg_amisha,
    output logic                    frame_amisha
);

    localparam int                  IDX_W       = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [IDX_W-1:0]    LAST_IDX    = IDX_W'(N_DIGITS - 1);
    localparam logic [BRIGHT_W-1:0] BRIGHT_FULL = '1;

    logic [REFRESH_BITS-1:0] presc_q, presc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    frame_q, frame_d;
    logic [4*N_DIGITS-1:0]   sh_hex_q, sh_hex_d, act_hex_q, act_hex_d;
    logic [N_DIGITS-1:0]     sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
    logic [N_DIGITS-1:0]     sh_blank_q, sh_blank_d, act_blank_q, act_blank_d;
    logic [N_DIGITS-1:0]     an_q, an_d;
    sseg_t                   sseg_q, sseg_d;

    logic                    slot_wrap;
    logic                    last_slot;
    logic                    boundary;
    logic [BRIGHT_W-1:0]     pw;
    logic                    pwm_on;
    logic [3:0]              sel_nibble;
    logic                    sel_dp;
    logic                    sel_blank;
    logic [N_DIGITS-1:0]     sel_an_n;
    seg7_t                   sel_seg;

    assign slot_wrap = &presc_q;
    assign last_slot = (idx_q == LAST_IDX);
    assign boundary  = slot_wrap & last_slot;

    // Sequencing and buffering: the shadow->active copy and the frame
    // pulse share the edge on which the index returns to zero.
    always_comb begin
        presc_d     = presc_q + REFRESH_BITS'(1);
        idx_d       = idx_q;
        if (slot_wrap) begin
            idx_d = last_slot ? '0 : idx_q + IDX_W'(1);
        end
        frame_d     = boundary;
        sh_hex_d    = load_amisha ? hex_amisha   : sh_hex_q;
        sh_dp_d     = load_amisha ? dp_amisha    : sh_dp_q;
        sh_blank_d  = load_amisha ? blank_amisha : sh_blank_q;
        act_hex_d   = boundary ? sh_hex_q   : act_hex_q;
        act_dp_d    = boundary ? sh_dp_q    : act_dp_q;
        act_blank_d = boundary ? sh_blank_q : act_blank_q;
    end

    // Digit select from the active copy only, so a frame never tears.
    always_comb begin
        sel_nibble = '0;
        sel_dp     = 1'b0;
        sel_blank  = 1'b1;
        sel_an_n   = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_nibble  = act_hex_q[4*i +: 4];
                sel_dp      = act_dp_q[i];
                sel_blank   = act_blank_q[i];
                sel_an_n[i] = 1'b0;
            end
        end
    end

    hex_to_sseg_amisha u_hex_to_sseg (
        .nibble_i (sel_nibble),
        .seg_o    (sel_seg)
    );

    assign pw     = presc_q[REFRESH_BITS-1 -: BRIGHT_W];
    assign pwm_on = (bright_amisha == BRIGHT_FULL) || (pw < bright_amisha);

    always_comb begin
        an_d   = '1;
        sseg_d = SEG_OFF;
        if (!sel_blank && pwm_on) begin
            an_d   = sel_an_n;
            sseg_d = pack_sseg(sel_dp, sel_seg);
        end
    end

    always_ff @(posedge clk_amisha or negedge reset_n_amisha) begin
        if (!reset_n_amisha) begin
            presc_q     <= '0;
            idx_q       <= '0;
            frame_q     <= 1'b0;
            sh_hex_q    <= '0;
            sh_dp_q     <= '0;
            sh_blank_q  <= '0;
            act_hex_q   <= '0;
            act_dp_q    <= '0;
            act_blank_q <= '0;
            an_q        <= '1;
            sseg_q      <= SEG_OFF;
        end else begin
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            frame_q     <= frame_d;
            sh_hex_q    <= sh_hex_d;
            sh_dp_q     <= sh_dp_d;
            sh_blank_q  <= sh_blank_d;
            act_hex_q   <= act_hex_d;
            act_dp_q    <= act_dp_d;
            act_blank_q <= act_blank_d;
            an_q        <= an_d;
            sseg_q      <= sseg_d;
        end
    end

    assign an_amisha    = an_q;
    assign sseg_amisha  = sseg_q;
    assign frame_amisha = frame_q;

endmodule
`default_nettype wire
